// File: rtl/exu_muldiv.sv
// exu_muldiv: iterative radix-2 shift-add multiplier and restoring divider for the EX stage.
// Stalls the pipeline front with md_busy while running and pulses md_done with the result.
module exu_muldiv #(
    parameter int XLEN = 64
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            ex_start,
    input  logic [2:0]      ex_md_op,
    input  logic [XLEN-1:0] ex_final_a,
    input  logic [XLEN-1:0] ex_final_b,
    input  logic            ex_flush,
    output logic            md_busy,
    output logic            md_done,
    output logic [XLEN-1:0] md_result
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

    state_t state, state_next;

    logic [2:0]        op_q;
    logic [XLEN-1:0]   a_q, b_q;
    logic              sign_a, sign_b;
    logic [2*XLEN-1:0] prod;
    logic [CW-1:0]     count;

    logic              is_div, sa_w, sb_w, special;
    logic [XLEN-1:0]   abs_a, abs_b, special_result;
    logic [XLEN:0]     mul_sum, rem_shift, div_diff;
    logic [2*XLEN-1:0] mul_step, div_step, prod_signed;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

    // Operand sign/magnitude decode and the early-exit divide cases, valid while in PREP
    always_comb begin
        is_div         = op_q[2];
        sa_w           = a_q[XLEN-1] & (op_q inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
        sb_w           = b_q[XLEN-1] & (op_q inside {OP_MULH, OP_DIV, OP_REM});
        abs_a          = sa_w ? -a_q : a_q;
        abs_b          = sb_w ? -b_q : b_q;
        special        = 1'b0;
        special_result = '0;
        if (is_div && b_q == '0) begin
            special        = 1'b1;
            special_result = op_q[1] ? a_q : '1;
        end else if ((op_q == OP_DIV || op_q == OP_REM) && a_q == MIN_NEG && b_q == '1) begin
            special        = 1'b1;
            special_result = op_q[1] ? '0 : a_q;
        end
    end

    // prod holds {accumulator, multiplier} for multiply and {remainder, quotient} for divide
    always_comb begin
        mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, a_q} : '0);
        mul_step  = {mul_sum, prod[XLEN-1:1]};
        rem_shift = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
        div_diff  = rem_shift - {1'b0, b_q};
        div_step  = div_diff[XLEN] ? {rem_shift[XLEN-1:0], prod[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], prod[XLEN-2:0], 1'b1};
    end

    always_comb begin
        prod_signed = (sign_a ^ sign_b) ? -prod : prod;
        quo_fix     = (sign_a ^ sign_b) ? -prod[XLEN-1:0] : prod[XLEN-1:0];
        rem_fix     = sign_a ? -prod[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];
        if (!is_div)
            fix_result = (op_q[1:0] == 2'b00) ? prod_signed[XLEN-1:0] : prod_signed[2*XLEN-1:XLEN];
        else
            fix_result = op_q[1] ? rem_fix : quo_fix;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (ex_start) state_next = PREP;
            PREP:    state_next = special ? DONE : CALC;
            CALC:    if (count == LAST) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (ex_flush) state_next = IDLE;
    end

    // The IDLE start term is combinational so the front end freezes in the request cycle
    always_comb begin
        md_busy = 1'b0;
        md_done = 1'b0;
        unique case (state)
            IDLE:            md_busy = ex_start & ~ex_flush;
            PREP, CALC, FIX: md_busy = 1'b1;
            DONE:            md_done = 1'b1;
            default:         md_busy = 1'b0;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            prod      <= '0;
            count     <= '0;
            md_result <= '0;
        end else if (!ex_flush) begin
            unique case (state)
                IDLE: begin
                    if (ex_start) begin
                        op_q <= ex_md_op;
                        a_q  <= ex_final_a;
                        b_q  <= ex_final_b;
                    end
                end
                PREP: begin
                    sign_a <= sa_w;
                    sign_b <= sb_w;
                    a_q    <= abs_a;
                    b_q    <= abs_b;
                    prod   <= {{XLEN{1'b0}}, is_div ? abs_a : abs_b};
                    count  <= '0;
                    if (special) md_result <= special_result;
                end
                CALC: begin
                    prod  <= is_div ? div_step : mul_step;
                    count <= count + CW'(1);
                end
                FIX:     md_result <= fix_result;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_exu_muldiv.sv
// tb_exu_muldiv: table-driven and randomized checks of exu_muldiv against an arithmetic model.
// Also covers flush, start-with-flush and mid-operation reset sequences.
module tb_exu_muldiv;
    localparam int XLEN        = 64;
    localparam int NORMAL_LAT  = XLEN + 3;
    localparam int SPECIAL_LAT = 2;
    localparam int NVEC        = 17;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  md_op;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [63:0] result;

    int assertions = 0;
    int failures   = 0;

    vec_t vecs[NVEC];

    exu_muldiv #(.XLEN(XLEN)) dut (
        .sys_clk    (clk),
        .sys_rst    (rst),
        .ex_start   (start),
        .ex_md_op   (md_op),
        .ex_final_a (op_a),
        .ex_final_b (op_b),
        .ex_flush   (flush),
        .md_busy    (busy),
        .md_done    (done),
        .md_result  (result)
    );

    always #5 clk = ~clk;

    // Reference results from plain wide arithmetic; divide corner cases follow the RISC-V rules
    function automatic logic [63:0] refModel(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] sa, sb, ua, ub, p;
        sa = {{64{a[63]}}, a};
        sb = {{64{b[63]}}, b};
        ua = {64'b0, a};
        ub = {64'b0, b};
        case (op)
            OP_MUL:    begin p = ua * ub; return p[63:0];   end
            OP_MULH:   begin p = sa * sb; return p[127:64]; end
            OP_MULHSU: begin p = sa * ub; return p[127:64]; end
            OP_MULHU:  begin p = ua * ub; return p[127:64]; end
            OP_DIV: begin
                if (b == 64'd0) return ONES;
                if (a == MINV && b == ONES) return a;
                return $signed(a) / $signed(b);
            end
            OP_DIVU:   return (b == 64'd0) ? ONES : a / b;
            OP_REM: begin
                if (b == 64'd0) return a;
                if (a == MINV && b == ONES) return 64'd0;
                return $signed(a) % $signed(b);
            end
            default:   return (b == 64'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int refLatency(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        if (op[2] && b == 64'd0) return SPECIAL_LAT;
        if ((op == OP_DIV || op == OP_REM) && a == MINV && b == ONES) return SPECIAL_LAT;
        return NORMAL_LAT;
    endfunction

    function automatic logic [63:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return 64'd1;
            2:       return ONES;
            3:       return MINV;
            4:       return ~MINV;
            5:       return 64'($urandom_range(0, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Runs one operation from its request cycle (cycle 0) through DONE and the cycle after
    task automatic applyStimulus(input string name, input logic [2:0] op, input logic [63:0] a,
                                 input logic [63:0] b, input logic [63:0] exp_res, input int exp_lat);
        int done_cycle;
        bit busy_ok;
        @(negedge clk);
        start = 1'b1;
        md_op = op;
        op_a  = a;
        op_b  = b;
        #1;
        busy_ok    = (busy === 1'b1) && (done === 1'b0);
        done_cycle = -1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            if (busy !== (cyc < exp_lat)) busy_ok = 1'b0;
            if (done === 1'b1) begin
                done_cycle = cyc;
                break;
            end
        end
        start = 1'b0;
        checkOutput({name, " done_cycle"}, 64'(done_cycle), 64'(exp_lat));
        checkOutput({name, " busy_profile"}, 64'(busy_ok), 64'd1);
        checkOutput({name, " result"}, result, exp_res);
        @(negedge clk);
        checkOutput({name, " single_pulse"}, {62'd0, done, busy}, 64'd0);
        checkOutput({name, " result_hold"}, result, exp_res);
    endtask

    initial begin
        logic [63:0] prev;
        bit saw_done;

        vecs[0]  = '{OP_MUL,    64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, NORMAL_LAT};
        vecs[1]  = '{OP_MULHU,  ONES,  64'd2, 64'd1,  NORMAL_LAT};
        vecs[2]  = '{OP_MULH,   ONES,  ONES,  64'd0,  NORMAL_LAT};
        vecs[3]  = '{OP_MULHSU, ONES,  64'd2, ONES,   NORMAL_LAT};
        vecs[4]  = '{OP_DIV,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, NORMAL_LAT};
        vecs[5]  = '{OP_REM,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, NORMAL_LAT};
        vecs[6]  = '{OP_DIVU,   64'd100, 64'd7, 64'd14, NORMAL_LAT};
        vecs[7]  = '{OP_REMU,   64'd100, 64'd7, 64'd2,  NORMAL_LAT};
        vecs[8]  = '{OP_DIVU,   64'd5, 64'd0, ONES,  SPECIAL_LAT};
        vecs[9]  = '{OP_REM,    64'd5, 64'd0, 64'd5, SPECIAL_LAT};
        vecs[10] = '{OP_DIV,    MINV,  ONES,  MINV,  SPECIAL_LAT};
        vecs[11] = '{OP_REM,    MINV,  ONES,  64'd0, SPECIAL_LAT};
        vecs[12] = '{OP_DIV,    64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, NORMAL_LAT};
        vecs[13] = '{OP_REM,    64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, NORMAL_LAT};
        vecs[14] = '{OP_MULH,   MINV,  MINV,  64'h4000_0000_0000_0000, NORMAL_LAT};
        vecs[15] = '{OP_DIVU,   MINV,  ONES,  64'd0, NORMAL_LAT};
        vecs[16] = '{OP_REMU,   MINV,  ONES,  MINV,  NORMAL_LAT};

        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        md_op = '0;
        op_a  = '0;
        op_b  = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset outputs", {61'd0, busy, done, |result}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post-reset result", result, 64'd0);

        for (int i = 0; i < NVEC; i++)
            applyStimulus($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);

        // Flush in cycle 10 of a DIV must drop back to IDLE with no result change
        prev = result;
        @(negedge clk);
        start = 1'b1;
        md_op = OP_DIVU;
        op_a  = 64'd1000;
        op_b  = 64'd3;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        #1;
        checkOutput("flush busy", {63'd0, busy}, 64'd0);
        checkOutput("flush result", result, prev);
        saw_done = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        checkOutput("flush no_done", 64'(saw_done), 64'd0);
        checkOutput("flush result_hold", result, prev);

        // Start together with flush in IDLE must not launch anything
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        md_op = OP_MUL;
        op_a  = 64'd3;
        op_b  = 64'd4;
        #1;
        checkOutput("start+flush busy", {63'd0, busy}, 64'd0);
        repeat (3) @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        #1;
        checkOutput("start+flush idle", {62'd0, busy, done}, 64'd0);
        checkOutput("start+flush result", result, prev);

        // Asynchronous reset in cycle 30 of a MUL clears everything immediately
        applyStimulus("pre-reset mul", OP_MUL, 64'd9, 64'd9, 64'd81, NORMAL_LAT);
        @(negedge clk);
        start = 1'b1;
        md_op = OP_MUL;
        op_a  = 64'd123;
        op_b  = 64'd456;
        repeat (30) @(negedge clk);
        #2;
        rst   = 1'b1;
        start = 1'b0;
        #1;
        checkOutput("midop reset flags", {62'd0, busy, done}, 64'd0);
        checkOutput("midop reset result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        checkOutput("midop reset no_done", 64'(saw_done), 64'd0);
        applyStimulus("mul after reset", OP_MUL, 64'd123, 64'd456, 64'd56088, NORMAL_LAT);

        for (int i = 0; i < 60; i++) begin
            logic [2:0]  rop;
            logic [63:0] ra, rb;
            rop = 3'($urandom_range(0, 7));
            ra  = pickOperand();
            rb  = pickOperand();
            applyStimulus($sformatf("rand%0d op%0d a=%h b=%h", i, rop, ra, rb),
                          rop, ra, rb, refModel(rop, ra, rb), refLatency(rop, ra, rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule

// File: doc/exu_muldiv.md
# exu_muldiv

Iterative multiply/divide unit in the execute stage, at the receiving end of the ID/EX pipeline register. It consumes the EX-stage operands and a multiply/divide opcode. It holds the front of the pipeline with a busy/stall signal while it runs a radix-2 shift-add multiply or a restoring divide. It returns one XLEN-bit result with a single-cycle done pulse, which the EX/MEM path captures alongside the ALU result.

## Interface
- XLEN, 64, operand/result width; must equal the global datapath width.
- sys_clk  in  1  clock; all state updates on posedge.
- sys_rst  in  1  reset, asynchronous, active-high.
- ex_start  in  1  multiply/divide instruction valid in EX; held high by EX while the instruction is frozen there.
- ex_md_op  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- ex_final_a  in  XLEN  operand A (multiplicand / dividend).
- ex_final_b  in  XLEN  operand B (multiplier / divisor).
- ex_flush  in  1  kill the in-flight operation (control hazard/redirect).
- md_busy  out  1  stall request to IF/ID and ID/EX.
- md_done  out  1  one-cycle pulse; md_result is valid.
- md_result  out  XLEN  result; holds its value until the next accepted start.

## Operation
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE: when ex_start=1 and ex_flush=0, latch the operands and the opcode, then go to PREP.
- PREP:
  - Record the operand signs: signed A for MULH, MULHSU, DIV, REM; signed B for MULH, DIV, REM.
  - Replace each signed operand by its absolute value.
  - Clear the accumulator and remainder; set the iteration counter to 0.
  - Special cases go directly to DONE and load the result:
    - divisor 0: DIV/DIVU give all ones; REM/REMU give A.
    - DIV with A = 0x8000…0 and B = all ones gives A; REM in the same case gives 0.
  - All other cases go to CALC.
- CALC: one radix-2 step per cycle for XLEN cycles (counter 0..XLEN-1).
  - Multiply: 2·XLEN-bit shift-add product.
  - Divide: restoring shift-subtract, producing quotient and remainder.
  - When counter = XLEN-1, go to FIX.
- FIX: sign correction, then go to DONE.
  - Negate the product if the signs differ (MULH: sA^sB; MULHSU: sA).
  - Negate the quotient if sA^sB; negate the remainder if sA (DIV/REM only).
  - Select the result: MUL low half; MULH* high half; DIV* quotient; REM* remainder.
  - Load md_result.
- DONE:
  - md_done=1 for exactly this cycle; md_busy=0, so the instruction advances this cycle.
  - Go to IDLE. ex_start is ignored in DONE.
- md_busy = (state ∈ {PREP, CALC, FIX}) | (state==IDLE & ex_start & ~ex_flush). The start term is combinational so the front end freezes in the request cycle.
- ex_flush has priority over every other input: any state goes to IDLE on the next edge, md_done is never raised for the killed operation, and md_result keeps its old value.
- ex_start while in PREP, CALC or FIX is ignored; operands are taken from the latched copies only.
- Arithmetic is modulo 2^XLEN; negation is two's complement. |0x8000…0| is taken as an unsigned magnitude, so no overflow results.

## Timing
- Reset value of every output and of all state: state IDLE, md_done 0, md_result 0. md_busy is 0 unless ex_start is high.
- Reset mid-operation: the unit returns to IDLE asynchronously and no md_done follows.
- Cycle 0 is the cycle in which ex_start is sampled in IDLE.
- Normal latency:
  - Cycle 1: PREP. Cycles 2..XLEN+1: CALC. Cycle XLEN+2: FIX.
  - Cycle XLEN+3: DONE, md_done=1 (cycle 67 for XLEN=64).
- Special-case latency: cycle 1 PREP, cycle 2 DONE, md_done=1.
- md_busy is high in cycles 0..XLEN+2 and low in DONE.
- Back-to-back operations: the next start is accepted in the cycle after DONE at the earliest.
- md_result changes only on the edge entering DONE (from FIX or PREP).

## Test plan
- MUL A=7, B=0xFFFF_FFFF_FFFF_FFFD → md_result 0xFFFF_FFFF_FFFF_FFEB; md_done only in cycle 67; md_busy high in cycles 0..66.
- MULHU A=all ones, B=2 → 1. MULH A=B=all ones → 0. MULHSU A=all ones, B=2 → all ones.
- DIV A=-7, B=2 → 0xFFFF_FFFF_FFFF_FFFD. REM A=-7, B=2 → all ones. DIVU A=100, B=7 → 14. REMU A=100, B=7 → 2.
- DIVU A=5, B=0 → all ones; REM A=5, B=0 → 5. Both give md_done in cycle 2. DIV A=0x8000…0, B=-1 → 0x8000…0; REM in the same case → 0.
- DIV started with ex_flush=1 in cycle 10 → IDLE in cycle 11, md_busy 0, no md_done, md_result unchanged. ex_start and ex_flush high together in IDLE → no start, md_busy 0.
- sys_rst pulsed in cycle 30 of a MUL → all outputs 0 immediately; a new MUL started after release completes normally in 67 cycles.
